adder_seq_ctrl: RTL

- Multi-cycle 64-bit add/subtract controller that time-shares one adder16 ripple slice across all 16-bit chunks of the operands.
- Trades latency for area: one slice is sequenced over WIDTH/SLICE cycles, with the carry registered between chunks.
- Sits between an issuing unit (valid/ready request) and a consumer (valid/ready result), e.g. the ALU in a small multi-cycle RISC-V datapath.

---
 rtl/adder_seq_ctrl_pkg.sv | 23 ++
 rtl/adder_seq_ctrl_adder16.sv | 28 ++
 rtl/adder_seq_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/adder_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle add/subtract controller:
// FSM state encoding and default datapath widths.
package adder_seq_ctrl_pkg;

  // Controller states. Encodings are fixed so that waveforms and any
  // software-visible debug taps read the same across builds.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width and width of the shared adder slice.
  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 16;

  // Width of a slice index for n slices; never narrower than one bit so
  // a single-slice build still has a legal index register.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_seq_ctrl_adder16.sv
// Ripple-carry adder slice. This is the only combinational arithmetic in
// the controller; it is instantiated once and time-shared across chunks.
module adder16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // carry[i] is the carry into bit i; carry[W] leaves the slice.
  logic [W:0] carry;

  assign carry[0] = cin;

  // One full adder per bit, chained through carry.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
    end
  endgenerate

  assign cout = carry[W];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract controller. One SLICE-bit adder is
// reused for WIDTH/SLICE cycles, least-significant chunk first, with the
// inter-chunk carry held in a register. Request and result sides use
// valid/ready handshakes; the result is held until the consumer takes it.
// WIDTH must be an integer multiple of SLICE.
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             startValid,
  output logic             startReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carryIn,
  output logic             resultValid,
  input  logic             resultReady,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             overflow,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = idx_bits(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t state_reg;
  state_t state_next;

  // Latched operands: b_reg already holds ~B for subtraction so the
  // slice only ever adds.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             carry_out_reg;
  logic             overflow_reg;
  logic [IDXW-1:0]  idx_reg;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic             last_chunk;
  logic             accept;

  // Chunk currently presented to the shared slice.
  assign slice_a    = a_reg[int'(idx_reg) * SLICE +: SLICE];
  assign slice_b    = b_reg[int'(idx_reg) * SLICE +: SLICE];
  assign last_chunk = (idx_reg == LAST_IDX);
  assign accept     = startValid && startReady;

  adder16 #(
    .W(SLICE)
  ) u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_reg),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    state_next  = state_reg;
    startReady  = 1'b0;
    resultValid = 1'b0;
    busy        = 1'b0;
    case (state_reg)
      IDLE: begin
        startReady = 1'b1;
        if (startValid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk) begin
          state_next = DONE;
        end
      end
      DONE: begin
        resultValid = 1'b1;
        if (resultReady) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, then fill one result chunk per
  // RUN cycle. Nothing here changes in DONE, which keeps the result stable
  // under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      idx_reg       <= '0;
    end else begin
      if (accept) begin
        a_reg     <= a;
        b_reg     <= sub ? ~b : b;
        // Subtraction is A + ~B + 1; carryIn only applies to addition.
        carry_reg <= sub | carryIn;
        idx_reg   <= '0;
        sum_reg   <= '0;
      end else if (state_reg == RUN) begin
        sum_reg[int'(idx_reg) * SLICE +: SLICE] <= slice_sum;
        carry_reg <= slice_cout;
        idx_reg   <= idx_reg + 1'b1;
        if (last_chunk) begin
          carry_out_reg <= slice_cout;
          // Signed overflow: operands agree in sign but the result does
          // not. The result MSB comes straight from the slice because it
          // is being written this same cycle.
          overflow_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                           (slice_sum[SLICE-1] != a_reg[WIDTH-1]);
        end
      end
    end
  end

  assign sum      = sum_reg;
  assign carryOut = carry_out_reg;
  assign overflow = overflow_reg;

endmodule
